io_pwr_seq_ctrl: RTL and testbench



---
 rtl/io_pwr_pkg.sv | 33 +++
 rtl/io_sync2.sv | 28 ++
 rtl/io_pwr_seq_ctrl.sv | 161 ++++++++++++++++
 tb/tb_io_pwr_seq_ctrl.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_pwr_pkg.sv
// io_pwr_pkg: shared state encodings and sizing helpers
// for the IO-ring power sequencer.
package io_pwr_pkg;

    localparam logic [2:0] S_OFF      = 3'd0;
    localparam logic [2:0] S_DEBOUNCE = 3'd1;
    localparam logic [2:0] S_SETTLE   = 3'd2;
    localparam logic [2:0] S_ON       = 3'd3;
    localparam logic [2:0] S_FAULT    = 3'd4;
    localparam logic [2:0] S_LOCK     = 3'd5;

    typedef enum logic [2:0] {
        ST_OFF      = S_OFF,
        ST_DEBOUNCE = S_DEBOUNCE,
        ST_SETTLE   = S_SETTLE,
        ST_ON       = S_ON,
        ST_FAULT    = S_FAULT,
        ST_LOCK     = S_LOCK
    } pwr_state_e;

    // Width able to hold the largest of the given counts.
    function automatic int cnt_width(input int a, input int b,
                                     input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        if (m < 1) m = 1;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/io_sync2.sv
// io_sync2: two-flop synchroniser for asynchronous pad-ring
// levels; both stages reset low.
module io_sync2
    import io_pwr_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic s1_q;
    logic s2_q;

    // Two-stage capture of the asynchronous level.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/io_pwr_seq_ctrl.sv
// io_pwr_seq_ctrl: debounced IO pad enable sequencer.
// Optional auto-retry / LOCK behaviour: IO_PWR_SEQ_RETRY_EN.
module io_pwr_seq_ctrl
    import io_pwr_pkg::*;
#(
    parameter int DEB_CYC    = 16,
    parameter int SETTLE_CYC = 64,
    parameter int RETRY_CYC  = 256,
    parameter int MAX_RETRY  = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vsup_ok,
    input  logic       fault_clr,
    output logic       pad_ie,
    output logic       pad_oe_en,
    output logic       pwr_good,
    output logic       fault,
    output logic [2:0] state_o
);

    localparam int CW =
        cnt_width(DEB_CYC, SETTLE_CYC, RETRY_CYC, MAX_RETRY);

    // OFF counts as the first high cycle, so DEBOUNCE
    // needs DEB_CYC-1 more, the last of which exits.
    localparam logic [CW-1:0] DEB_LAST =
        CW'((DEB_CYC >= 2) ? DEB_CYC - 2 : 0);
    localparam logic [CW-1:0] SET_LAST = CW'(SETTLE_CYC - 1);

    logic          vs_sync;
    pwr_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic          fault_q, fault_d;
    logic          ie_q, oe_q, pg_q;

`ifdef IO_PWR_SEQ_RETRY_EN
    localparam int RW = cnt_width(MAX_RETRY, 0, 0, 0);
    localparam logic [CW-1:0] RTY_LAST = CW'(RETRY_CYC - 1);
    localparam logic [RW-1:0] RTY_MAX  = RW'(MAX_RETRY);
    logic [RW-1:0] retry_q, retry_d;
`endif

    io_sync2 u_vs_sync (
        .clk (clk),
        .rst (rst),
        .d_i (vsup_ok),
        .q_o (vs_sync)
    );

    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);

    // Next-state, counter and sticky fault logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fault_d = fault_q;
`ifdef IO_PWR_SEQ_RETRY_EN
        retry_d = retry_q;
`endif
        if (fault_clr) fault_d = 1'b0;
        unique case (state_q)
            ST_OFF: begin
                cnt_d = '0;
                if (vs_sync)
                    state_d = (DEB_CYC == 1) ? ST_SETTLE : ST_DEBOUNCE;
            end
            ST_DEBOUNCE: begin
                if (!vs_sync) begin
                    state_d = ST_OFF;
                    cnt_d   = '0;
                end else if (cnt_q >= DEB_LAST) begin
                    state_d = ST_SETTLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_SETTLE, ST_ON: begin
                if (!vs_sync) begin
                    fault_d = 1'b1;
                    cnt_d   = '0;
`ifdef IO_PWR_SEQ_RETRY_EN
                    state_d = (retry_q == RTY_MAX) ? ST_LOCK : ST_FAULT;
`else
                    state_d = ST_FAULT;
`endif
                end else if (state_q == ST_SETTLE) begin
                    if (cnt_q >= SET_LAST) begin
                        state_d = ST_ON;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            ST_FAULT: begin
                if (fault_clr) begin
                    state_d = ST_OFF;
                    cnt_d   = '0;
                end
`ifdef IO_PWR_SEQ_RETRY_EN
                else if (cnt_q >= RTY_LAST) begin
                    state_d = ST_OFF;
                    cnt_d   = '0;
                    if (retry_q != '1) retry_d = retry_q + RW'(1);
                end else begin
                    cnt_d = cnt_inc;
                end
`endif
            end
`ifdef IO_PWR_SEQ_RETRY_EN
            ST_LOCK: begin
                if (fault_clr) begin
                    state_d = ST_OFF;
                    cnt_d   = '0;
                    retry_d = '0;
                end
            end
`endif
            default: begin
                state_d = ST_OFF;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counters and Moore outputs registered together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_OFF;
            cnt_q   <= '0;
            fault_q <= 1'b0;
            ie_q    <= 1'b0;
            oe_q    <= 1'b0;
            pg_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
            ie_q    <= (state_d == ST_SETTLE) || (state_d == ST_ON);
            oe_q    <= (state_d == ST_ON);
            pg_q    <= (state_d == ST_ON);
        end
    end

`ifdef IO_PWR_SEQ_RETRY_EN
    // Auto-retry count, cleared only by reset or LOCK release.
    always_ff @(posedge clk) begin
        if (rst) retry_q <= '0;
        else     retry_q <= retry_d;
    end
`endif

    assign pad_ie    = ie_q;
    assign pad_oe_en = oe_q;
    assign pwr_good  = pg_q;
    assign fault     = fault_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_io_pwr_seq_ctrl.sv
// tb_io_pwr_seq_ctrl: directed checks of the IO power
// sequencer with DEB_CYC=4, SETTLE_CYC=8, RETRY_CYC=8, MAX_RETRY=1.
module tb_io_pwr_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       vsup_ok = 1'b0;
    logic       fault_clr = 1'b0;
    logic       pad_ie, pad_oe_en, pwr_good, fault;
    logic [2:0] state_o;

    int total = 0;
    int bad   = 0;

    io_pwr_seq_ctrl #(
        .DEB_CYC    (4),
        .SETTLE_CYC (8),
        .RETRY_CYC  (8),
        .MAX_RETRY  (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .vsup_ok   (vsup_ok),
        .fault_clr (fault_clr),
        .pad_ie    (pad_ie),
        .pad_oe_en (pad_oe_en),
        .pwr_good  (pwr_good),
        .fault     (fault),
        .state_o   (state_o)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        vsup_ok = 1'b0;
        fault_clr = 1'b0;
        step(3);
        total++;
        if ({pad_ie, pad_oe_en, pwr_good, fault} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_outs got=%b want=0000",
                     {pad_ie, pad_oe_en, pwr_good, fault});
        end
        total++;
        if (state_o !== 3'd0) begin
            bad++;
            $display("FAIL reset_state got=%0d want=0", state_o);
        end
        rst = 1'b0;
        step(2);
        total++;
        if ({pad_ie, state_o} !== 4'b0000) begin
            bad++;
            $display("FAIL idle_off got=%b want=0000", {pad_ie, state_o});
        end
    endtask

    // vsup_ok rises after "edge 0"; expects pad_ie from edge 6,
    // pad_oe_en/pwr_good from edge 14.
    task automatic check_power_up(input string tag);
        logic e_ie, e_on;
        for (int e = 1; e <= 16; e++) begin
            step(1);
            e_ie = (e >= 6);
            e_on = (e >= 14);
            total++;
            if ({pad_ie, pad_oe_en, pwr_good, fault} !==
                {e_ie, e_on, e_on, 1'b0}) begin
                bad++;
                $display("FAIL %s_e%0d got=%b want=%b", tag, e,
                         {pad_ie, pad_oe_en, pwr_good, fault},
                         {e_ie, e_on, e_on, 1'b0});
            end
            if (e == 3 || e == 6 || e == 14) begin
                total++;
                if (state_o !== ((e == 3) ? 3'd1 :
                                 (e == 6) ? 3'd2 : 3'd3)) begin
                    bad++;
                    $display("FAIL %s_state_e%0d got=%0d", tag, e,
                             state_o);
                end
            end
        end
    endtask

    task automatic test_power_up;
        vsup_ok = 1'b1;
        check_power_up("pwrup");
    endtask

    task automatic test_loss;
        vsup_ok = 1'b0;
        step(2);
        total++;
        if ({pad_oe_en, fault, state_o} !== 5'b10_011) begin
            bad++;
            $display("FAIL loss_pre got=%b want=10011",
                     {pad_oe_en, fault, state_o});
        end
        step(1);
        total++;
        if ({pad_ie, pad_oe_en, pwr_good, fault} !== 4'b0001) begin
            bad++;
            $display("FAIL loss_outs got=%b want=0001",
                     {pad_ie, pad_oe_en, pwr_good, fault});
        end
        total++;
        if (state_o !== 3'd4) begin
            bad++;
            $display("FAIL loss_state got=%0d want=4", state_o);
        end
        step(4);
        total++;
        if ({fault, state_o} !== 4'b1_100) begin
            bad++;
            $display("FAIL fault_hold got=%b want=1100", {fault, state_o});
        end
        fault_clr = 1'b1;
        step(1);
        fault_clr = 1'b0;
        total++;
        if ({fault, state_o} !== 4'b0_000) begin
            bad++;
            $display("FAIL fault_clr got=%b want=0000", {fault, state_o});
        end
    endtask

    task automatic test_debounce_abort;
        logic seen_ie;
        seen_ie = 1'b0;
        vsup_ok = 1'b1;
        step(2);
        vsup_ok = 1'b0;
        step(1);
        total++;
        if (state_o !== 3'd1) begin
            bad++;
            $display("FAIL deb_enter got=%0d want=1", state_o);
        end
        for (int e = 0; e < 8; e++) begin
            step(1);
            seen_ie |= pad_ie | fault;
        end
        total++;
        if (seen_ie !== 1'b0) begin
            bad++;
            $display("FAIL deb_ie_fault got=%b want=0", seen_ie);
        end
        total++;
        if (state_o !== 3'd0) begin
            bad++;
            $display("FAIL deb_abort got=%0d want=0", state_o);
        end
    endtask

    task automatic test_clr_vs_loss;
        vsup_ok = 1'b1;
        step(16);
        vsup_ok = 1'b0;
        step(2);
        fault_clr = 1'b1;
        step(1);
        fault_clr = 1'b0;
        total++;
        if ({fault, state_o} !== 4'b1_100) begin
            bad++;
            $display("FAIL clash got=%b want=1100", {fault, state_o});
        end
        step(1);
        total++;
        if ({fault, state_o, pad_ie} !== 5'b1_100_0) begin
            bad++;
            $display("FAIL clash_hold got=%b want=11000",
                     {fault, state_o, pad_ie});
        end
        fault_clr = 1'b1;
        step(1);
        fault_clr = 1'b0;
        total++;
        if ({fault, state_o} !== 4'b0_000) begin
            bad++;
            $display("FAIL clash_clr got=%b want=0000", {fault, state_o});
        end
    endtask

    task automatic test_rst_settle;
        vsup_ok = 1'b1;
        step(8);
        total++;
        if ({state_o, pad_ie} !== 4'b010_1) begin
            bad++;
            $display("FAIL rst_pre got=%b want=0101", {state_o, pad_ie});
        end
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        total++;
        if ({pad_ie, pad_oe_en, pwr_good, fault, state_o} !== 7'd0) begin
            bad++;
            $display("FAIL rst_mid got=%b want=0000000",
                     {pad_ie, pad_oe_en, pwr_good, fault, state_o});
        end
        check_power_up("restart");
    endtask

`ifdef IO_PWR_SEQ_RETRY_EN
    task automatic test_retry_lock;
        rst = 1'b1;
        vsup_ok = 1'b0;
        step(2);
        rst = 1'b0;
        vsup_ok = 1'b1;
        step(16);
        vsup_ok = 1'b0;
        step(3);
        total++;
        if ({fault, state_o} !== 4'b1_100) begin
            bad++;
            $display("FAIL rty_fault got=%b want=1100", {fault, state_o});
        end
        step(7);
        total++;
        if (state_o !== 3'd4) begin
            bad++;
            $display("FAIL rty_wait got=%0d want=4", state_o);
        end
        step(1);
        total++;
        if ({fault, state_o} !== 4'b1_000) begin
            bad++;
            $display("FAIL rty_auto got=%b want=1000", {fault, state_o});
        end
        vsup_ok = 1'b1;
        step(16);
        total++;
        if ({pwr_good, state_o} !== 4'b1_011) begin
            bad++;
            $display("FAIL rty_up got=%b want=1011", {pwr_good, state_o});
        end
        vsup_ok = 1'b0;
        step(3);
        total++;
        if ({pad_ie, pad_oe_en, pwr_good, fault, state_o} !==
            7'b0001_101) begin
            bad++;
            $display("FAIL lock got=%b want=0001101",
                     {pad_ie, pad_oe_en, pwr_good, fault, state_o});
        end
        step(12);
        total++;
        if (state_o !== 3'd5) begin
            bad++;
            $display("FAIL lock_hold got=%0d want=5", state_o);
        end
        fault_clr = 1'b1;
        step(1);
        fault_clr = 1'b0;
        total++;
        if ({fault, state_o} !== 4'b0_000) begin
            bad++;
            $display("FAIL lock_clr got=%b want=0000", {fault, state_o});
        end
    endtask
`endif

    initial begin
        test_reset();
        test_power_up();
        test_loss();
        test_debounce_abort();
        test_clr_vs_loss();
        test_rst_settle();
`ifdef IO_PWR_SEQ_RETRY_EN
        test_retry_lock();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
